pwm_multi: RTL and testbench

PWM_MULTI -- requirements
Module: pwm_multi

---
 rtl/pwm_multi.sv | 97 +++++++++
 tb/tb_pwm_multi.sv | 116 +++++++++++
 2 files changed

// File: rtl/pwm_multi.sv
// Multi-channel PWM generator. All channels share one period counter; period and duty
// values are taken from shadow registers, which are reloaded only at a period boundary.
module pwm_multi #(
  parameter int CH = 4,
  parameter int W  = 8
) (
  input  logic            clk,
  input  logic            resetb,
  input  logic            en,
  input  logic [W-1:0]    period,
  input  logic [CH*W-1:0] duty,
  input  logic            load,
  input  logic [CH-1:0]   pol,
  output logic [CH-1:0]   pwm_out,
  output logic            period_end,
  output logic            busy
);

  // state | meaning
  // IDLE  | stopped, outputs at inactive level
  // RUN   | counting, shadows may reload at boundary
  // DRAIN | en dropped, finishing current period
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t            state, state_nxt;
  logic [W-1:0]      cnt, period_s;
  logic [CH*W-1:0]   duty_s;
  logic              load_pend;
  logic [CH-1:0]     raw, raw_q;
  logic              running, at_end, take_new;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en) state_nxt = RUN;
      RUN:     if (!en) state_nxt = DRAIN;
      DRAIN: begin
        if (en)          state_nxt = RUN;
        else if (at_end) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    running  = (state != IDLE);
    at_end   = (cnt == period_s);
    take_new = (state == RUN) && at_end && (load_pend || load);
    raw      = '0;
    for (int i = 0; i < CH; i++)
      raw[i] = running && (cnt < duty_s[i*W +: W]);
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      cnt        <= '0;
      period_s   <= '0;
      duty_s     <= '0;
      load_pend  <= 1'b0;
      raw_q      <= '0;
      period_end <= 1'b0;
      busy       <= 1'b0;
    end else begin
      raw_q      <= raw;
      period_end <= running && at_end;
      busy       <= (state_nxt != IDLE);
      if (state == IDLE) begin
        if (en) begin
          cnt       <= '0;
          period_s  <= period;
          duty_s    <= duty;
          load_pend <= 1'b0;
        end
      end else begin
        cnt <= at_end ? '0 : cnt + 1'b1;
        if (take_new) begin
          period_s  <= period;
          duty_s    <= duty;
          load_pend <= 1'b0;
        end else if (state_nxt == IDLE) begin
          load_pend <= 1'b0;
        end else if (load) begin
          load_pend <= 1'b1;
        end
      end
    end
  end

  // Polarity is applied after the register, so reset shows the inactive level at once.
  assign pwm_out = raw_q ^ pol;

endmodule

// File: tb/tb_pwm_multi.sv
// Directed bench for pwm_multi: duty patterns, deferred load, drain, 1-cycle period, async reset.
module tb_pwm_multi;
  localparam int CH = 4;
  localparam int W  = 8;

  logic            clk = 1'b0;
  logic            resetb, en, load;
  logic [W-1:0]    period;
  logic [CH*W-1:0] duty;
  logic [CH-1:0]   pol;
  logic [CH-1:0]   pwm_out;
  logic            period_end, busy;
  int              total = 0;
  int              bad = 0;

  always #5 clk = ~clk;

  pwm_multi #(.CH(CH), .W(W)) dut (
    .clk(clk), .resetb(resetb), .en(en), .period(period), .duty(duty),
    .load(load), .pol(pol), .pwm_out(pwm_out), .period_end(period_end), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] exp_pwm(input int ph, input int d0, input int d1,
                                         input int d2, input int d3);
    exp_pwm = {ph < d3, ph < d2, ph < d1, ph < d0};
  endfunction

  initial begin
    resetb = 1'b0; en = 1'b0; load = 1'b0; period = '0; duty = '0; pol = '0;
    #2;
    chk("rst_pwm", 32'(pwm_out), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_pe", 32'(period_end), 32'h0);
    pol = 4'b0001;
    #1 chk("rst_pol", 32'(pwm_out), 32'h1);
    @(negedge clk) resetb = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_pol", 32'(pwm_out), 32'h1);
    chk("idle_busy", 32'(busy), 32'h0);

    // period 10, duty ch3..ch0 = 5,10,0,3
    pol = '0; period = 8'd9; duty = {8'd5, 8'd10, 8'd0, 8'd3}; en = 1'b1;
    @(negedge clk);
    chk("start_busy", 32'(busy), 32'h1);
    chk("start_pwm", 32'(pwm_out), 32'h0);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      chk("run_pwm", 32'(pwm_out), 32'(exp_pwm(k % 10, (k >= 40) ? 7 : 3, 0, 10, 5)));
      chk("run_pe", 32'(period_end), 32'((k % 10) == 9));
      chk("run_busy", 32'(busy), 32'h1);
      if (k == 33) begin load = 1'b1; duty[7:0] = 8'd7; end
      if (k == 34) load = 1'b0;
      if (k == 41) begin period = 8'd4; duty[31:24] = 8'd1; end
    end

    // drop en at cnt=2: period completes, then idle
    for (int k = 50; k < 65; k++) begin
      @(negedge clk);
      if (k < 60) begin
        chk("drain_pwm", 32'(pwm_out), 32'(exp_pwm(k % 10, 7, 0, 10, 5)));
        chk("drain_pe", 32'(period_end), 32'((k % 10) == 9));
        chk("drain_busy", 32'(busy), 32'(k < 59));
      end else begin
        chk("off_pwm", 32'(pwm_out), 32'h0);
        chk("off_pe", 32'(period_end), 32'h0);
        chk("off_busy", 32'(busy), 32'h0);
      end
      if (k == 51) en = 1'b0;
    end

    // one-cycle period
    period = 8'd0; duty = {24'd0, 8'd1}; en = 1'b1;
    @(negedge clk);
    chk("p0_busy", 32'(busy), 32'h1);
    chk("p0_first_pe", 32'(period_end), 32'h0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("p0_pwm", 32'(pwm_out), 32'h1);
      chk("p0_pe", 32'(period_end), 32'h1);
    end
    pol = 4'b0001;
    #1 chk("pol_inv", 32'(pwm_out), 32'h0);
    #2 resetb = 1'b0;
    #1;
    chk("arst_pwm", 32'(pwm_out), 32'h1);
    chk("arst_busy", 32'(busy), 32'h0);
    chk("arst_pe", 32'(period_end), 32'h0);
    en = 1'b0;
    @(negedge clk);
    resetb = 1'b1; pol = '0;
    @(negedge clk);
    chk("post_rst_pwm", 32'(pwm_out), 32'h0);
    chk("post_rst_busy", 32'(busy), 32'h0);

    // restart after reset: period 4, ch0 duty 2
    period = 8'd3; duty = {24'd0, 8'd2}; en = 1'b1;
    @(negedge clk);
    chk("restart_busy", 32'(busy), 32'h1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("restart_pwm", 32'(pwm_out), 32'(exp_pwm(k % 4, 2, 0, 0, 0)));
      chk("restart_pe", 32'(period_end), 32'((k % 4) == 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
